// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/grant and serial-output bundle for uart_tx_sched.
// master = requester/observer side, slave = the scheduler itself.
interface uart_tx_sched_if;
    logic [3:0]  REQ;    // per-requester level request, held until granted
    logic [31:0] DIN;    // byte i on DIN[8i+7:8i]
    logic [3:0]  GNT;    // one-hot capture pulse
    logic        TXD;    // serial line, idle high
    logic        BUSY;   // frame in progress
    logic [1:0]  OWNER;  // requester of current / last frame

    modport master (output REQ, DIN, input GNT, TXD, BUSY, OWNER);
    modport slave  (input REQ, DIN, output GNT, TXD, BUSY, OWNER);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: 4-requester round-robin UART transmit scheduler.
// Grants one requester from IDLE, captures its byte and sends
// start + 8 data (LSB first) + stop, each bit one BDCLK interval.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_sched (
    input  logic            CLK,
    input  logic            RST,
    input  logic            BDCLK,
    uart_tx_sched_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ALIGN  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif
    localparam logic [2:0] STOP   = 3'd5;

    logic [2:0] state;
    logic       txd;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [2:0] cnt;
    logic [7:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       grant;
    logic [7:0] win_byte;

    // Round-robin search: first asserted request from ptr upward, wrapping.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Grant is combinational so the requester sees it in the capture cycle;
    // reset suppresses it so a same-cycle reset wins over a request.
    assign grant    = (state == IDLE) && !RST && found;
    assign win_byte = bus.DIN[{win, 3'b000} +: 8];

    assign bus.GNT   = grant ? (4'b0001 << win) : 4'b0000;
    assign bus.TXD   = txd;
    assign bus.BUSY  = (state != IDLE);
    assign bus.OWNER = owner;

    // Frame sequencer: TXD only ever moves on a BDCLK edge outside IDLE,
    // and the grant cycle never consumes a tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            txd   <= 1'b1;
            owner <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 3'd0;
            shreg <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        shreg <= win_byte;
                        owner <= win;
                        ptr   <= win + 2'd1;
`ifdef UART_TX_PARITY_EN
                        par   <= ^win_byte;
`endif
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (BDCLK) begin
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (BDCLK) begin
                        txd   <= shreg[0];
                        cnt   <= 3'd0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (BDCLK) begin
                        if (cnt != 3'd7) begin
                            txd   <= shreg[1];
                            shreg <= {1'b0, shreg[7:1]};
                            cnt   <= cnt + 3'd1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            txd   <= par;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (BDCLK) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (BDCLK) begin
                        txd   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_sched;
    logic CLK = 1'b0;
    logic RST;
    logic BDCLK;
    int   checks = 0;
    int   errors = 0;

    uart_tx_sched_if bus();

    uart_tx_sched dut (
        .CLK   (CLK),
        .RST   (RST),
        .BDCLK (BDCLK),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Two quiet cycles (TXD must hold), then a one-cycle BDCLK pulse.
    task automatic tick();
        logic t;
        t = bus.TXD;
        repeat (2) begin
            step();
            chk("txd_hold", 32'(bus.TXD), 32'(t));
        end
        BDCLK = 1'b1;
        #1;
        chk("gnt_quiet", 32'(bus.GNT), 32'd0);
        step();
        BDCLK = 1'b0;
    endtask

    task automatic grant(input logic [3:0] req, input logic [31:0] din, input int g, input string tag);
        bus.REQ = req;
        bus.DIN = din;
        #1;
        chk(tag, 32'(bus.GNT), 32'(4'b0001 << g));
        step();
        chk("owner", 32'(bus.OWNER), 32'(g));
        chk("busy_align", 32'(bus.BUSY), 32'd1);
        chk("txd_align", 32'(bus.TXD), 32'd1);
    endtask

    task automatic frame(input logic [7:0] b);
        tick();
        chk("start", 32'(bus.TXD), 32'd0);
        chk("busy", 32'(bus.BUSY), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("data", 32'(bus.TXD), 32'(b[i]));
        end
`ifdef UART_TX_PARITY_EN
        tick();
        chk("parity", 32'(bus.TXD), 32'(^b));
`endif
        tick();
        chk("stop", 32'(bus.TXD), 32'd1);
        chk("busy_stop", 32'(bus.BUSY), 32'd1);
        tick();
        chk("idle_txd", 32'(bus.TXD), 32'd1);
        chk("idle_busy", 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        // Reset with request and tick asserted: reset must win.
        RST = 1'b1;
        BDCLK = 1'b1;
        bus.REQ = 4'b0001;
        bus.DIN = 32'h0;
        #1;
        chk("rst_gnt0", 32'(bus.GNT), 32'd0);
        step();
        chk("rst_gnt1", 32'(bus.GNT), 32'd0);
        step();
        RST = 1'b0;
        BDCLK = 1'b0;
        bus.REQ = 4'b0000;
        chk("rst_txd", 32'(bus.TXD), 32'd1);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_owner", 32'(bus.OWNER), 32'd0);
        #1;
        chk("rst_gnt", 32'(bus.GNT), 32'd0);

        // Single 0x55 frame from requester 0.
        grant(4'b0001, 32'h0000_0055, 0, "gnt_55");
        bus.REQ = 4'b0000;
        frame(8'h55);
        chk("owner_hold", 32'(bus.OWNER), 32'd0);

        // All requesting: round robin 0,1,2,3,0, back-to-back frames.
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int n = 0; n < 5; n++) begin
            grant(4'b1111, 32'hA3A2_A1A0, n % 4, "gnt_rr");
            frame(8'hA0 + 8'(n % 4));
        end
        bus.REQ = 4'b0000;

        // Tick coincident with grant is ignored; ptr is now 1.
        bus.REQ = 4'b0100;
        bus.DIN = 32'h00C5_0000;
        BDCLK = 1'b1;
        #1;
        chk("gnt_tick", 32'(bus.GNT), 32'h4);
        step();
        BDCLK = 1'b0;
        bus.REQ = 4'b0000;
        chk("no_early_start", 32'(bus.TXD), 32'd1);
        chk("owner_tick", 32'(bus.OWNER), 32'd2);
        frame(8'hC5);

        // DIN/REQ change after grant must not leak into the frame.
        grant(4'b1000, 32'h3C00_0000, 3, "gnt_din");
        bus.REQ = 4'b0000;
        bus.DIN = 32'hFFFF_FFFF;
        frame(8'h3C);

        // Abort during data bit 4; ptr would be 3 without the reset.
        grant(4'b0100, 32'h0086_0000, 2, "gnt_abort");
        bus.REQ = 4'b0000;
        for (int n = 0; n < 6; n++) tick();
        chk("bit4", 32'(bus.TXD), 32'd0);
        RST = 1'b1;
        bus.REQ = 4'b1010;
        bus.DIN = 32'h0000_5A00;
        #1;
        chk("rst_mid_gnt", 32'(bus.GNT), 32'd0);
        step();
        RST = 1'b0;
        chk("abort_txd", 32'(bus.TXD), 32'd1);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_owner", 32'(bus.OWNER), 32'd0);
        grant(4'b1010, 32'h0000_5A00, 1, "gnt_after_rst");
        bus.REQ = 4'b0000;
        frame(8'h5A);

`ifdef UART_TX_PARITY_EN
        // Parity 1 then parity 0 (ptr is 2 here).
        grant(4'b0100, 32'h0007_0000, 2, "gnt_par1");
        bus.REQ = 4'b0000;
        frame(8'h07);
        grant(4'b1000, 32'h0300_0000, 3, "gnt_par0");
        bus.REQ = 4'b0000;
        frame(8'h03);
`endif

        step();
        chk("final_gnt", 32'(bus.GNT), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
